sm83_bus: RTL and testbench
===========================

SM83_BUS -- requirements
Module: sm83_bus

Interface
REQ-001 SHALL have parameter DMA_LEN, default 160, meaning the number of bytes per OAM DMA transfer.
REQ-002 SHALL have parameter HRAM_BASE, default 16'hFF80, meaning the first HRAM address (the region ends at FFFE).
REQ-003 clk  in  1  single clock for all state; one clock, reset is synchronous and active-high.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 cpu_addr  in  16  CPU address bus.
REQ-006 cpu_wdata  in  8  CPU write data (the core's d_out).
REQ-007 cpu_write  in  1  CPU write strobe; the write commits on the rising edge where it is 1.
REQ-008 cpu_rdata  out  8  read data to the core's d_in; registered.
REQ-009 ext_addr  out  16  external (cart/VRAM/WRAM) address.
REQ-010 ext_wdata  out  8  external write data.
REQ-011 ext_we  out  1  external write enable.
REQ-012 ext_rdata  in  8  external read data; combinational from ext_addr.
REQ-013 oam_addr  out  8  OAM byte index (0-159).
REQ-014 oam_wdata  out  8  OAM write data.
REQ-015 oam_we  out  1  OAM write enable.
REQ-016 oam_rdata  in  8  OAM read data; combinational from oam_addr.
REQ-017 dma_active  out  1  high while an OAM DMA is in progress.

Function
REQ-018 Address decode SHALL be as follows:
- FF80-FFFE: internal HRAM, 127x8.
- FFFF: IE register, 8-bit read/write.
- FF46: DMA register.
- FE00-FE9F: OAM.
- FEA0-FEFF: unusable; reads return 8'hFF and writes are ignored.
- All other addresses: external.
REQ-019 cpu_rdata SHALL be registered every clock from the region selected by cpu_addr, so read data is valid one clock after the address.
REQ-020 While the DMA is idle, ext_addr and ext_wdata SHALL pass through cpu_addr and cpu_wdata combinationally, with ext_we = cpu_write && external region.
REQ-021 While the DMA is idle, oam_addr SHALL equal cpu_addr[7:0], with oam_we = cpu_write && OAM region.
REQ-022 A read of FF46 SHALL return the last value written to it.
REQ-023 A CPU write of v to FF46 SHALL latch v and start the DMA on the next clock, with source base {s,8'h00}, where s = v-8'h20 if v>=8'hE0, else s = v.
REQ-024 The DMA FSM SHALL have states IDLE, RD, WR:
- IDLE->RD on start.
- In RD: ext_addr = base+i, ext_we=0, and the byte from ext_rdata is captured.
- RD->WR always.
- In WR: oam_addr=i, oam_wdata=captured byte, oam_we=1.
- WR->RD with i+1 while i<DMA_LEN-1; otherwise WR->IDLE.
REQ-025 A full DMA SHALL take exactly 2*DMA_LEN clocks, and dma_active SHALL be high in RD and WR only.
REQ-026 During DMA, CPU reads outside FF80-FFFF SHALL return 8'hFF, and CPU writes there SHALL be dropped; ext_we SHALL stay 0.
REQ-027 During DMA, HRAM, IE and FF46 SHALL stay fully accessible.
REQ-028 A write to FF46 during DMA SHALL restart the transfer with i=0 and the new base on the next clock; the remaining old bytes are not copied.
REQ-029 The counter i SHALL be 8 bits and SHALL never exceed DMA_LEN-1.
REQ-030 oam_we and ext_we SHALL never be 1 in the same clock.

Reset
REQ-031 On reset, the following SHALL apply:
- cpu_rdata=8'hFF.
- IE=8'h00.
- FF46 register=8'h00.
- FSM=IDLE, i=0, dma_active=0.
- ext_we=0, oam_we=0.
- HRAM contents are not cleared.
REQ-032 A reset asserted mid-DMA SHALL abort the DMA in the same clock, with no further OAM writes.

Structure
REQ-033 A shared package SHALL hold the region boundary constants, the FF46/FFFF addresses, the DMA_LEN default and the dma_state_t enum {IDLE,RD,WR}.
REQ-034 HRAM SHALL be a sub-module sm83_hram (127x8, synchronous write, combinational read, no reset).

Verification
REQ-035 Write 8'h5A to FF80, then read FF80: cpu_rdata=8'h5A one clock after the address; ext_we=0 throughout.
REQ-036 Write 8'hC0 to FF46 with ext memory at C000+k = k^8'hA5: dma_active is high for 320 clocks, OAM[k] = k^8'hA5 for k=0..159, and oam_we pulses 160 times.
REQ-037 During DMA, a CPU read of C000 returns 8'hFF, a CPU write to C000 produces no ext_we, and a read of FFFF returns IE.
REQ-038 Write 8'hE1 to FF46: the first RD ext_addr is 16'hC100, and a read of FF46 returns 8'hE1.
REQ-039 Rewrite FF46 at i=50: the next RD uses the new base with i=0; assert reset mid-DMA and dma_active=0, oam_we=0 on the next clock.

Source files
------------

// File: rtl/sm83_bus_pkg.sv
// Shared constants, types and address decode for the SM83 memory bus.
package sm83_bus_pkg;

    localparam int unsigned ADDR_W          = 16;
    localparam int unsigned DATA_W          = 8;
    localparam int unsigned HRAM_AW         = 7;
    localparam int unsigned HRAM_DEPTH      = 127;
    localparam int unsigned DMA_LEN_DEFAULT = 160;

    localparam logic [15:0] HRAM_BASE_DEFAULT = 16'hFF80;
    localparam logic [15:0] HRAM_LAST         = 16'hFFFE;
    localparam logic [15:0] IE_ADDR           = 16'hFFFF;
    localparam logic [15:0] DMA_ADDR          = 16'hFF46;
    localparam logic [15:0] OAM_BASE          = 16'hFE00;
    localparam logic [15:0] OAM_LAST          = 16'hFE9F;
    localparam logic [15:0] UNUSED_BASE       = 16'hFEA0;
    localparam logic [15:0] UNUSED_LAST       = 16'hFEFF;

    typedef enum logic [1:0] {IDLE, RD, WR} dma_state_t;

    typedef enum logic [2:0] {
        REG_HRAM, REG_IE, REG_DMA, REG_OAM, REG_UNUSED, REG_EXT
    } region_t;

    function automatic region_t decode(input logic [15:0] a, input logic [15:0] hram_base);
        if (a == IE_ADDR) return REG_IE;
        if (a >= hram_base && a <= HRAM_LAST) return REG_HRAM;
        if (a == DMA_ADDR) return REG_DMA;
        if (a >= OAM_BASE && a <= OAM_LAST) return REG_OAM;
        if (a >= UNUSED_BASE && a <= UNUSED_LAST) return REG_UNUSED;
        return REG_EXT;
    endfunction

    // Sources at E000 and above mirror the echo region down by 0x2000.
    function automatic logic [15:0] dma_src(input logic [7:0] v);
        logic [7:0] s;
        s = (v >= 8'hE0) ? (v - 8'h20) : v;
        return {s, 8'h00};
    endfunction

endpackage

// File: rtl/sm83_bus_if.sv
// CPU, external-memory and OAM signals of the SM83 bus.
interface sm83_bus_if;
    import sm83_bus_pkg::*;

    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_write;
    logic [DATA_W-1:0] cpu_rdata;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_we;
    logic [DATA_W-1:0] ext_rdata;
    logic [7:0]        oam_addr;
    logic [DATA_W-1:0] oam_wdata;
    logic              oam_we;
    logic [DATA_W-1:0] oam_rdata;
    logic              dma_active;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_write, ext_rdata, oam_rdata,
        output cpu_rdata, ext_addr, ext_wdata, ext_we,
        output oam_addr, oam_wdata, oam_we, dma_active
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_write, ext_rdata, oam_rdata,
        input  cpu_rdata, ext_addr, ext_wdata, ext_we,
        input  oam_addr, oam_wdata, oam_we, dma_active
    );

endinterface

// File: rtl/sm83_hram.sv
// High RAM: synchronous write, combinational read, contents survive reset.
module sm83_hram
    import sm83_bus_pkg::*;
#(
    parameter int unsigned DEPTH = HRAM_DEPTH
) (
    input  logic               clk,
    input  logic               we,
    input  logic [HRAM_AW-1:0] addr,
    input  logic [7:0]         wdata,
    output logic [7:0]         rdata_c
);

    logic [7:0] mem [DEPTH];
    logic       in_range;

    assign in_range = 32'(addr) < DEPTH;
    assign rdata_c  = in_range ? mem[addr] : 8'hFF;

    always_ff @(posedge clk) begin
        if (we && in_range) mem[addr] <= wdata;
    end

endmodule

// File: rtl/sm83_bus.sv
// SM83 address decoder with HRAM, IE and an OAM DMA engine that locks the CPU out of the main bus.
module sm83_bus
    import sm83_bus_pkg::*;
#(
    parameter int unsigned DMA_LEN   = DMA_LEN_DEFAULT,
    parameter logic [15:0] HRAM_BASE = HRAM_BASE_DEFAULT
) (
    input logic       clk,
    input logic       reset,
    sm83_bus_if.slave bus
);

    dma_state_t  state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [15:0] base_q, base_d;
    logic [7:0]  byte_q;
    logic [7:0]  ie_q;
    logic [7:0]  dma_reg_q;
    logic [7:0]  hram_rdata;
    logic [7:0]  rd_mux;
    region_t     region;
    logic        busy;
    logic        dma_wr;
    logic        hram_we;

    assign region  = decode(bus.cpu_addr, HRAM_BASE);
    assign busy    = state_q != IDLE;
    assign dma_wr  = bus.cpu_write && region == REG_DMA;
    assign hram_we = bus.cpu_write && region == REG_HRAM;

    sm83_hram u_hram (
        .clk     (clk),
        .we      (hram_we),
        .addr    (HRAM_AW'(bus.cpu_addr - HRAM_BASE)),
        .wdata   (bus.cpu_wdata),
        .rdata_c (hram_rdata)
    );

    // DMA state register; the source byte is captured at the end of each RD cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 8'h00;
            base_q  <= 16'h0000;
            byte_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            if (state_q == RD) byte_q <= bus.ext_rdata;
        end
    end

    // Next state: an FF46 write (re)starts from byte 0 regardless of the current state.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        if (dma_wr) begin
            state_d = RD;
            idx_d   = 8'h00;
            base_d  = dma_src(bus.cpu_wdata);
        end else begin
            case (state_q)
                RD: state_d = WR;
                WR: begin
                    if (idx_q < 8'(DMA_LEN - 1)) begin
                        state_d = RD;
                        idx_d   = idx_q + 8'h01;
                    end else begin
                        state_d = IDLE;
                        idx_d   = 8'h00;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus outputs: pass-through when idle, DMA-owned otherwise; reset kills strobes immediately.
    always_comb begin
        bus.ext_addr   = bus.cpu_addr;
        bus.ext_wdata  = bus.cpu_wdata;
        bus.ext_we     = 1'b0;
        bus.oam_addr   = bus.cpu_addr[7:0];
        bus.oam_wdata  = bus.cpu_wdata;
        bus.oam_we     = 1'b0;
        bus.dma_active = busy;
        if (busy) begin
            bus.ext_addr  = base_q + 16'(idx_q);
            bus.oam_addr  = idx_q;
            bus.oam_wdata = byte_q;
            bus.oam_we    = (state_q == WR) && !reset;
        end else begin
            bus.ext_we = bus.cpu_write && region == REG_EXT && !reset;
            bus.oam_we = bus.cpu_write && region == REG_OAM && !reset;
        end
    end

    always_comb begin
        rd_mux = 8'hFF;
        case (region)
            REG_HRAM:   rd_mux = hram_rdata;
            REG_IE:     rd_mux = ie_q;
            REG_DMA:    rd_mux = dma_reg_q;
            REG_OAM:    rd_mux = busy ? 8'hFF : bus.oam_rdata;
            REG_UNUSED: rd_mux = 8'hFF;
            default:    rd_mux = busy ? 8'hFF : bus.ext_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ie_q          <= 8'h00;
            dma_reg_q     <= 8'h00;
            bus.cpu_rdata <= 8'hFF;
        end else begin
            if (bus.cpu_write && region == REG_IE) ie_q <= bus.cpu_wdata;
            if (dma_wr) dma_reg_q <= bus.cpu_wdata;
            bus.cpu_rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_sm83_bus.sv
// Scoreboard bench for sm83_bus: read expectations are queued by stimulus and checked by a monitor.
module tb_sm83_bus;
    import sm83_bus_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sm83_bus_if bus_if();

    sm83_bus dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    // External memory: byte = lo ^ hi ^ 0x65, so C000+k reads k^A5 and C100+k reads k^A4.
    function automatic logic [7:0] ext_model(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h65;
    endfunction

    logic [7:0] oam_mem [160];
    assign bus_if.ext_rdata = ext_model(bus_if.ext_addr);
    assign bus_if.oam_rdata = (bus_if.oam_addr < 8'd160) ? oam_mem[bus_if.oam_addr] : 8'h00;
    always @(posedge clk) if (bus_if.oam_we && bus_if.oam_addr < 8'd160) oam_mem[bus_if.oam_addr] <= bus_if.oam_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Read scoreboard
    logic [7:0] exp_q[$];
    string      name_q[$];
    logic       rd_issue = 1'b0;
    logic       rd_valid = 1'b0;

    always @(posedge clk) rd_valid <= rd_issue;

    always @(negedge clk) begin : rd_monitor
        logic [7:0] e;
        string      nm;
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected", 16'(exp_q.size()), 16'd1);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check(nm, 16'(bus_if.cpu_rdata), 16'(e));
            end
        end
    end

    // Bus activity monitor
    int act_cnt = 0, we_cnt = 0, ext_we_cnt = 0, overlap = 0, ext_in_dma = 0;
    logic [15:0] last_ext_addr;
    logic [7:0]  last_ext_wdata;
    always @(negedge clk) begin
        if (bus_if.dma_active) act_cnt++;
        if (bus_if.oam_we) we_cnt++;
        if (bus_if.ext_we) begin
            ext_we_cnt++;
            last_ext_addr  = bus_if.ext_addr;
            last_ext_wdata = bus_if.ext_wdata;
        end
        if (bus_if.ext_we && bus_if.oam_we) overlap++;
        if (bus_if.ext_we && bus_if.dma_active) ext_in_dma++;
    end

    // All stimulus tasks start and end at a falling edge.
    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        bus_if.cpu_addr  = a;
        bus_if.cpu_wdata = d;
        bus_if.cpu_write = 1'b1;
        @(negedge clk);
        bus_if.cpu_write = 1'b0;
    endtask

    task automatic cpu_rd(input logic [15:0] a, input logic [7:0] e, input string nm);
        bus_if.cpu_addr  = a;
        bus_if.cpu_write = 1'b0;
        rd_issue         = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        rd_issue = 1'b0;
    endtask

    task automatic wait_dma_done(input string nm);
        for (int c = 0; c < 2000 && bus_if.dma_active; c++) @(negedge clk);
        check(nm, 16'(bus_if.dma_active), 16'd0);
    endtask

    task automatic wait_oam_wr(input logic [7:0] idx, input string nm);
        logic found;
        found = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (bus_if.oam_we && bus_if.oam_addr == idx) begin
                found = 1'b1;
                break;
            end
        end
        check(nm, 16'(found), 16'd1);
    endtask

    int snap;

    initial begin
        bus_if.cpu_addr  = 16'h0000;
        bus_if.cpu_wdata = 8'h00;
        bus_if.cpu_write = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rdata", 16'(bus_if.cpu_rdata), 16'h00FF);
        check("rst_dma_active", 16'(bus_if.dma_active), 16'd0);
        check("rst_oam_we", 16'(bus_if.oam_we), 16'd0);
        check("rst_ext_we", 16'(bus_if.ext_we), 16'd0);
        reset = 1'b0;
        cpu_rd(16'hFFFF, 8'h00, "rst_ie");
        cpu_rd(16'hFF46, 8'h00, "rst_ff46");

        // HRAM, IE, unusable region and idle pass-through
        cpu_wr(16'hFF80, 8'h5A);
        cpu_rd(16'hFF80, 8'h5A, "hram_ff80");
        cpu_wr(16'hFFFE, 8'h3C);
        cpu_rd(16'hFFFE, 8'h3C, "hram_fffe");
        cpu_wr(16'hFFFF, 8'h1F);
        cpu_rd(16'hFFFF, 8'h1F, "ie_rw");
        check("hram_no_ext_we", 16'(ext_we_cnt), 16'd0);
        cpu_rd(16'hC012, 8'hB7, "ext_read_idle");
        cpu_rd(16'hFEA0, 8'hFF, "unusable_read");
        snap = we_cnt;
        cpu_wr(16'hFEA5, 8'h11);
        check("unusable_no_ext_we", 16'(ext_we_cnt), 16'd0);
        check("unusable_no_oam_we", 16'(we_cnt), 16'(snap));
        cpu_wr(16'hFE10, 8'h77);
        cpu_rd(16'hFE10, 8'h77, "oam_cpu_rw");
        cpu_wr(16'hC005, 8'h99);
        check("ext_we_count", 16'(ext_we_cnt), 16'd1);
        check("ext_we_addr", last_ext_addr, 16'hC005);
        check("ext_we_data", 16'(last_ext_wdata), 16'h0099);

        // Full DMA from C000 with CPU traffic during the transfer
        act_cnt = 0;
        we_cnt  = 0;
        snap    = ext_we_cnt;
        cpu_wr(16'hFF46, 8'hC0);
        check("dma_first_rd_addr", bus_if.ext_addr, 16'hC000);
        repeat (10) @(negedge clk);
        cpu_rd(16'hC000, 8'hFF, "dma_ext_read_blocked");
        cpu_wr(16'hC000, 8'h33);
        cpu_rd(16'hFFFF, 8'h1F, "dma_ie_read");
        cpu_wr(16'hFF81, 8'h42);
        cpu_rd(16'hFF81, 8'h42, "dma_hram_rw");
        cpu_rd(16'hFF46, 8'hC0, "dma_ff46_read");
        cpu_rd(16'hFE00, 8'hFF, "dma_oam_read_blocked");
        wait_dma_done("dma1_timeout");
        check("dma1_active_cycles", 16'(act_cnt), 16'd320);
        check("dma1_oam_we_pulses", 16'(we_cnt), 16'd160);
        check("dma1_no_ext_we", 16'(ext_we_cnt), 16'(snap));
        for (int k = 0; k < 160; k++)
            check($sformatf("dma1_oam[%0d]", k), 16'(oam_mem[k]), 16'(8'(k) ^ 8'hA5));

        // Echo-region source E1 maps to C100
        cpu_wr(16'hFF46, 8'hE1);
        check("e1_first_rd_addr", bus_if.ext_addr, 16'hC100);
        check("e1_dma_active", 16'(bus_if.dma_active), 16'd1);
        cpu_rd(16'hFF46, 8'hE1, "e1_ff46_read");
        wait_dma_done("dma2_timeout");
        check("e1_oam[0]", 16'(oam_mem[0]), 16'h00A4);
        check("e1_oam[159]", 16'(oam_mem[159]), 16'h003B);

        // Restart at i=50, then reset mid-transfer
        cpu_wr(16'hFF46, 8'hC0);
        wait_oam_wr(8'd50, "wait_i50");
        cpu_wr(16'hFF46, 8'hD0);
        check("restart_rd_addr", bus_if.ext_addr, 16'hD000);
        check("restart_oam_we", 16'(bus_if.oam_we), 16'd0);
        check("restart_idx", 16'(bus_if.oam_addr), 16'd0);
        wait_oam_wr(8'd20, "wait_i20");
        reset = 1'b1;
        #1;
        check("reset_same_clk_oam_we", 16'(bus_if.oam_we), 16'd0);
        @(negedge clk);
        check("reset_dma_active", 16'(bus_if.dma_active), 16'd0);
        check("reset_oam_we", 16'(bus_if.oam_we), 16'd0);
        check("reset_rdata", 16'(bus_if.cpu_rdata), 16'h00FF);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_idle", 16'(bus_if.dma_active), 16'd0);
        check("restart_oam[0]", 16'(oam_mem[0]), 16'h00B5);
        check("restart_oam[19]", 16'(oam_mem[19]), 16'h00A6);
        check("aborted_oam[20]", 16'(oam_mem[20]), 16'h00B1);
        check("untouched_oam[60]", 16'(oam_mem[60]), 16'h0098);
        cpu_rd(16'hFFFF, 8'h00, "post_reset_ie");
        cpu_rd(16'hFF46, 8'h00, "post_reset_ff46");
        cpu_rd(16'hFF80, 8'h5A, "hram_kept_ff80");
        cpu_rd(16'hFF81, 8'h42, "hram_kept_ff81");

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        check("no_we_overlap", 16'(overlap), 16'd0);
        check("no_ext_we_in_dma", 16'(ext_in_dma), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
